// File: rtl/qr_pkg.sv
// Shared constants and types for the Givens QR array input path.
// Elements are (20,10) two's-complement fixed point.
package qr_pkg;

  localparam int QR_DATA_WIDTH = 20;
  localparam int QR_N          = 4;
  localparam int QR_FRAC_BITS  = 10;

  typedef logic [QR_DATA_WIDTH-1:0] qr_data_t;

  typedef enum logic {
    LOAD = 1'b0,
    FEED = 1'b1
  } skew_state_t;

  function automatic int qr_clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/qr_skew_bank.sv
// N x N element bank: row-major write port, one read port per column.
// A same-cycle write to the addressed cell is forwarded to the reader.
module qr_skew_bank
  import qr_pkg::*;
#(
  parameter int DATA_WIDTH = QR_DATA_WIDTH,
  parameter int N          = QR_N,
  parameter int RW         = qr_clog2_min1(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [RW-1:0]           i_wrow,
  input  logic [RW-1:0]           i_wcol,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [N*RW-1:0]         i_rd_row,
  output logic [N*DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [N][N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wrow][i_wcol] <= i_wdata;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int j = 0; j < N; j++) begin
      if (i_we &&
          i_wrow == i_rd_row[j*RW +: RW] &&
          i_wcol == RW'(j)) begin
        o_rd_data[j*DATA_WIDTH +: DATA_WIDTH] = i_wdata;
      end else begin
        o_rd_data[j*DATA_WIDTH +: DATA_WIDTH] =
          r_mem[i_rd_row[j*RW +: RW]][j];
      end
    end
  end

endmodule

// File: rtl/qr_input_skew.sv
// Skewed-wavefront feeder for the systolic Givens QR array.
// Define QR_SKEW_DBLBUF_EN for ping-pong banks (load next matrix during feed).
module qr_input_skew
  import qr_pkg::*;
#(
  parameter int DATA_WIDTH  = QR_DATA_WIDTH,
  parameter int N           = QR_N,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [N*DATA_WIDTH-1:0] col_data,
  output logic [N-1:0]            col_valid,
  output logic                    feed_done
);

  localparam int EW = qr_clog2_min1(N*N);
  localparam int TW = qr_clog2_min1(2*N-1);
  localparam int HW = qr_clog2_min1(HOLD_CYCLES);
  localparam int RW = qr_clog2_min1(N);

  localparam logic [EW-1:0] EC_LAST = EW'(N*N-1);
  localparam logic [TW-1:0] T_LAST  = TW'(2*N-2);
  localparam logic [HW-1:0] H_LAST  = HW'(HOLD_CYCLES-1);

  skew_state_t r_state, w_state_n;
  logic [EW-1:0] r_ec, w_ec_n;
  logic [TW-1:0] r_t, w_t_n;
  logic [HW-1:0] r_h, w_h_n;
  logic [1:0]    r_full, w_full_n;
  logic          r_wsel, w_wsel_n;
  logic          r_rsel, w_rsel_n;
  logic          r_in_ready, w_in_ready_n;

  logic [N-1:0]            r_col_valid, w_col_valid_n;
  logic [N*DATA_WIDTH-1:0] r_col_data, w_col_data_n;

  logic                    w_acc;
  logic [RW-1:0]           w_wrow, w_wcol;
  logic [N*RW-1:0]         w_rd_row;
  logic [N*DATA_WIDTH-1:0] w_rd0, w_rd1;

  assign w_acc  = in_valid && r_in_ready;
  assign w_wrow = RW'(int'(r_ec) / N);
  assign w_wcol = RW'(int'(r_ec) % N);

  assign in_ready  = r_in_ready;
  assign col_valid = r_col_valid;
  assign col_data  = r_col_data;
  assign feed_done = (r_state == FEED) &&
                     (r_t == T_LAST) &&
                     (r_h == H_LAST);

  qr_skew_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .N(N),
    .RW(RW)
  ) u_bank0 (
    .clk(clk),
    .rst(rst),
    .i_we(w_acc && !r_wsel),
    .i_wrow(w_wrow),
    .i_wcol(w_wcol),
    .i_wdata(in_data),
    .i_rd_row(w_rd_row),
    .o_rd_data(w_rd0)
  );

`ifdef QR_SKEW_DBLBUF_EN
  qr_skew_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .N(N),
    .RW(RW)
  ) u_bank1 (
    .clk(clk),
    .rst(rst),
    .i_we(w_acc && r_wsel),
    .i_wrow(w_wrow),
    .i_wcol(w_wcol),
    .i_wdata(in_data),
    .i_rd_row(w_rd_row),
    .o_rd_data(w_rd1)
  );
`else
  assign w_rd1 = '0;
`endif

  // Load side fills the write bank; feed side walks t/h over the read bank.
  always_comb begin
    w_state_n = r_state;
    w_ec_n    = r_ec;
    w_t_n     = r_t;
    w_h_n     = r_h;
    w_full_n  = r_full;
    w_wsel_n  = r_wsel;
    w_rsel_n  = r_rsel;
    if (w_acc) begin
      if (r_ec == EC_LAST) begin
        w_ec_n           = '0;
        w_full_n[r_wsel] = 1'b1;
`ifdef QR_SKEW_DBLBUF_EN
        w_wsel_n         = ~r_wsel;
`endif
      end else begin
        w_ec_n = r_ec + 1'b1;
      end
    end
    unique case (r_state)
      LOAD: begin
        if (w_acc && r_ec == EC_LAST) begin
          w_state_n = FEED;
          w_t_n     = '0;
          w_h_n     = '0;
          w_rsel_n  = r_wsel;
        end
      end
      FEED: begin
        if (r_h == H_LAST) begin
          w_h_n = '0;
          if (r_t == T_LAST) begin
            w_full_n[r_rsel] = 1'b0;
            w_t_n            = '0;
            if (w_full_n[!r_rsel]) begin
              w_rsel_n = !r_rsel;
            end else begin
              w_state_n = LOAD;
            end
          end else begin
            w_t_n = r_t + 1'b1;
          end
        end else begin
          w_h_n = r_h + 1'b1;
        end
      end
      default: w_state_n = LOAD;
    endcase
    w_in_ready_n = !w_full_n[w_wsel_n];
  end

  always_comb begin
    w_col_valid_n = '0;
    w_rd_row      = '0;
    for (int j = 0; j < N; j++) begin
      if (w_state_n == FEED &&
          int'(w_t_n) >= j &&
          int'(w_t_n) - j < N) begin
        w_col_valid_n[j]     = 1'b1;
        w_rd_row[j*RW +: RW] = RW'(int'(w_t_n) - j);
      end
    end
  end

  always_comb begin
    w_col_data_n = '0;
    for (int j = 0; j < N; j++) begin
      if (w_col_valid_n[j]) begin
        w_col_data_n[j*DATA_WIDTH +: DATA_WIDTH] = w_rsel_n ?
          w_rd1[j*DATA_WIDTH +: DATA_WIDTH] :
          w_rd0[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LOAD;
      r_ec        <= '0;
      r_t         <= '0;
      r_h         <= '0;
      r_full      <= '0;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_col_valid <= '0;
      r_col_data  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_ec        <= w_ec_n;
      r_t         <= w_t_n;
      r_h         <= w_h_n;
      r_full      <= w_full_n;
      r_wsel      <= w_wsel_n;
      r_rsel      <= w_rsel_n;
      r_in_ready  <= w_in_ready_n;
      r_col_valid <= w_col_valid_n;
      r_col_data  <= w_col_data_n;
    end
  end

endmodule
